// File: rtl/ring_phase_collector_if.sv
// rtl/ring_phase_collector_if.sv - ring phase/data input and frame output bundle for ring_phase_collector
//
// Purpose: groups the ring-side inputs (phase, din), the frame handshake
// (out_ready/frame_valid) and the frame/status outputs of the collector.
// Modports:
//   master - ring stage / consumer side: drives phase, din, out_ready
//   slave  - collector side: drives frame_valid, frame_sum, frame_xor,
//            phase_idx, phase_err, overrun, err_count
interface ring_phase_collector_if #(
  parameter int WIDTH = 8
);
  logic [7:0]       phase;
  logic [WIDTH-1:0] din;
  logic             out_ready;
  logic             frame_valid;
  logic [WIDTH+2:0] frame_sum;
  logic [WIDTH-1:0] frame_xor;
  logic [2:0]       phase_idx;
  logic             phase_err;
  logic             overrun;
  logic [7:0]       err_count;

  modport master (
    output phase, din, out_ready,
    input  frame_valid, frame_sum, frame_xor, phase_idx, phase_err, overrun, err_count
  );

  modport slave (
    input  phase, din, out_ready,
    output frame_valid, frame_sum, frame_xor, phase_idx, phase_err, overrun, err_count
  );
endinterface

// File: rtl/ring_phase_collector.sv
// rtl/ring_phase_collector.sv - checks one-hot ring order and collects per-phase bytes into sum/XOR frames
//
// Purpose: follows an 8-bit one-hot ring (01 -> 02 -> ... -> 80), accumulates
// one data byte per phase and, after a full revolution, presents the frame sum
// and XOR on a valid/ready output register. Sequence errors and dropped frames
// are pulsed and counted.
// Ports:
//   clk   - rising-edge clock
//   clear - synchronous active-low reset
//   bus   - ring_phase_collector_if.slave: phase, din, out_ready in;
//           frame_valid, frame_sum, frame_xor, phase_idx, phase_err,
//           overrun, err_count out (all registered)
// Optional macro: RING_ONEHOT_CHECK_EN - while waiting for sync, a non-one-hot
//   phase is also reported as a sequence error.
module ring_phase_collector #(
  parameter int WIDTH   = 8,
  parameter int ERR_MAX = 255
) (
  input  logic                    clk,
  input  logic                    clear,
  ring_phase_collector_if.slave   bus
);

  typedef enum logic [0:0] {
    WAIT_SYNC,
    COLLECT
  } state_t;

  state_t           state;
  logic [WIDTH+2:0] acc_sum;
  logic [WIDTH-1:0] acc_xor;
  logic [7:0]       exp_phase;

  logic             is_onehot;
  logic [2:0]       idx;
  logic [WIDTH+2:0] sum_next;
  logic [WIDTH-1:0] xor_next;
  logic             can_load;
  logic             err_sat;

  always_comb begin
    is_onehot = (bus.phase != 8'h00) && ((bus.phase & (bus.phase - 8'h01)) == 8'h00);
    idx       = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bus.phase == (8'h01 << i)) idx = 3'(i);
    end
    sum_next  = acc_sum + {3'b000, bus.din};
    xor_next  = acc_xor ^ bus.din;
    // A completing frame may load if the output slot is empty or is being
    // drained on this same edge.
    can_load  = !bus.frame_valid || bus.out_ready;
    err_sat   = (bus.err_count == 8'(ERR_MAX));
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      state           <= WAIT_SYNC;
      acc_sum         <= '0;
      acc_xor         <= '0;
      exp_phase       <= 8'h00;
      bus.frame_valid <= 1'b0;
      bus.frame_sum   <= '0;
      bus.frame_xor   <= '0;
      bus.phase_idx   <= 3'd0;
      bus.phase_err   <= 1'b0;
      bus.overrun     <= 1'b0;
      bus.err_count   <= 8'h00;
    end else begin
      bus.phase_idx <= is_onehot ? idx : 3'd0;
      bus.phase_err <= 1'b0;
      bus.overrun   <= 1'b0;

      // Drain on transfer; a completion below overrides this with new data.
      if (bus.frame_valid && bus.out_ready) bus.frame_valid <= 1'b0;

      case (state)
        WAIT_SYNC: begin
          if (bus.phase == 8'h01) begin
            acc_sum   <= {3'b000, bus.din};
            acc_xor   <= bus.din;
            exp_phase <= 8'h02;
            state     <= COLLECT;
          end
`ifdef RING_ONEHOT_CHECK_EN
          else if (!is_onehot) begin
            bus.phase_err <= 1'b1;
            if (!err_sat) bus.err_count <= bus.err_count + 8'h01;
          end
`endif
        end

        COLLECT: begin
          if (bus.phase == exp_phase) begin
            if (exp_phase == 8'h80) begin
              if (can_load) begin
                bus.frame_sum   <= sum_next;
                bus.frame_xor   <= xor_next;
                bus.frame_valid <= 1'b1;
              end else begin
                bus.overrun <= 1'b1;
              end
              acc_sum   <= '0;
              acc_xor   <= '0;
              exp_phase <= 8'h00;
              state     <= WAIT_SYNC;
            end else begin
              acc_sum   <= sum_next;
              acc_xor   <= xor_next;
              exp_phase <= exp_phase << 1;
            end
          end else begin
            // The erroring cycle itself is never taken as a sync, even if it is 01.
            bus.phase_err <= 1'b1;
            if (!err_sat) bus.err_count <= bus.err_count + 8'h01;
            acc_sum   <= '0;
            acc_xor   <= '0;
            exp_phase <= 8'h00;
            state     <= WAIT_SYNC;
          end
        end

        default: state <= WAIT_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_phase_collector.sv
// tb/tb_ring_phase_collector.sv - self-checking scoreboard bench for ring_phase_collector
module tb_ring_phase_collector;

  typedef struct {
    logic [10:0] sum;
    logic [7:0]  x;
  } frame_t;

  logic clk;
  logic clear;
  int   checks;
  int   errors;
  frame_t exp_q[$];

  ring_phase_collector_if #(.WIDTH(8)) bus ();

  ring_phase_collector #(.WIDTH(8), .ERR_MAX(255)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every accepted transfer pops the oldest expected frame.
  always @(negedge clk) begin
    if (clear && bus.frame_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame sum=%0d xor=%h with empty scoreboard", bus.frame_sum, bus.frame_xor);
      end else begin
        frame_t e;
        e = exp_q.pop_front();
        if (bus.frame_sum !== e.sum || bus.frame_xor !== e.x) begin
          errors++;
          $display("FAIL frame_transfer got sum=%0d xor=%h required sum=%0d xor=%h",
                   bus.frame_sum, bus.frame_xor, e.sum, e.x);
        end
      end
    end
  end

  task automatic drive(input logic [7:0] p, input logic [7:0] d);
    bus.phase = p;
    bus.din   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [10:0] s, input logic [7:0] x);
    frame_t f;
    f.sum = s;
    f.x   = x;
    exp_q.push_back(f);
  endtask

  task automatic test_reset;
    clear = 1'b0;
    bus.out_ready = 1'b0;
    drive(8'h00, 8'h00);
    drive(8'h00, 8'h00);
    checks++;
    if (bus.frame_valid !== 1'b0 || bus.frame_sum !== 11'd0 || bus.frame_xor !== 8'h00 ||
        bus.phase_idx !== 3'd0 || bus.phase_err !== 1'b0 || bus.overrun !== 1'b0 || bus.err_count !== 8'h00) begin
      errors++;
      $display("FAIL reset_state got v=%b s=%0d x=%h idx=%0d pe=%b ov=%b ec=%0d required all 0",
               bus.frame_valid, bus.frame_sum, bus.frame_xor, bus.phase_idx, bus.phase_err, bus.overrun, bus.err_count);
    end
    clear = 1'b1;
  endtask

  task automatic test_basic_ring;
    bus.out_ready = 1'b1;
    push_frame(11'd36, 8'h08);
    for (int i = 0; i < 8; i++) begin
      drive(8'h01 << i, 8'(i + 1));
      checks++;
      if (bus.phase_idx !== 3'(i)) begin
        errors++;
        $display("FAIL phase_idx got %0d required %0d", bus.phase_idx, i);
      end
    end
    checks++;
    if (bus.frame_valid !== 1'b1 || bus.frame_sum !== 11'd36 || bus.frame_xor !== 8'h08) begin
      errors++;
      $display("FAIL basic_frame got v=%b s=%0d x=%h required v=1 s=36 x=08", bus.frame_valid, bus.frame_sum, bus.frame_xor);
    end
    drive(8'h00, 8'h00);
    checks++;
    if (bus.frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain got v=%b required 0", bus.frame_valid);
    end
  endtask

  task automatic test_back_to_back;
    bus.out_ready = 1'b1;
    push_frame(11'd2040, 8'h00);
    push_frame(11'd2040, 8'h00);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) begin
        drive(8'h01 << i, 8'hFF);
        checks++;
        if (bus.overrun !== 1'b0 || bus.phase_err !== 1'b0) begin
          errors++;
          $display("FAIL b2b_status got ov=%b pe=%b required 0 0", bus.overrun, bus.phase_err);
        end
      end
    end
    drive(8'h00, 8'h00);
    drive(8'h00, 8'h00);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_frames got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_phase_error;
    bus.out_ready = 1'b1;
    drive(8'h01, 8'h11);
    drive(8'h02, 8'h22);
    drive(8'h04, 8'h33);
    drive(8'h04, 8'h44);
    checks++;
    if (bus.phase_err !== 1'b1 || bus.err_count !== 8'd1) begin
      errors++;
      $display("FAIL seq_error got pe=%b ec=%0d required pe=1 ec=1", bus.phase_err, bus.err_count);
    end
    drive(8'h00, 8'h00);
    checks++;
    if (bus.phase_err !== 1'b0 || bus.frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL seq_error_after got pe=%b v=%b required 0 0", bus.phase_err, bus.frame_valid);
    end
    push_frame(11'd576, 8'h80);
    for (int i = 0; i < 8; i++) drive(8'h01 << i, 8'((i + 1) * 16));
    checks++;
    if (bus.frame_valid !== 1'b1 || bus.frame_sum !== 11'd576 || bus.frame_xor !== 8'h80) begin
      errors++;
      $display("FAIL resync_frame got v=%b s=%0d x=%h required v=1 s=576 x=80", bus.frame_valid, bus.frame_sum, bus.frame_xor);
    end
    drive(8'h00, 8'h00);
  endtask

  task automatic test_overrun;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) drive(8'h01 << i, 8'(i + 1));
    for (int i = 0; i < 8; i++) drive(8'h01 << i, 8'h02);
    checks++;
    if (bus.overrun !== 1'b1 || bus.frame_valid !== 1'b1 || bus.frame_sum !== 11'd36 || bus.frame_xor !== 8'h08) begin
      errors++;
      $display("FAIL overrun_hold got ov=%b v=%b s=%0d x=%h required ov=1 v=1 s=36 x=08",
               bus.overrun, bus.frame_valid, bus.frame_sum, bus.frame_xor);
    end
    drive(8'h00, 8'h00);
    checks++;
    if (bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_pulse got %b required 0", bus.overrun);
    end
    push_frame(11'd36, 8'h08);
    bus.out_ready = 1'b1;
    drive(8'h00, 8'h00);
    checks++;
    if (bus.frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_drain got v=%b required 0", bus.frame_valid);
    end
  endtask

  task automatic test_load_on_transfer;
    bus.out_ready = 1'b0;
    push_frame(11'd24, 8'h00);
    for (int i = 0; i < 8; i++) drive(8'h01 << i, 8'h03);
    push_frame(11'd40, 8'h00);
    for (int i = 0; i < 7; i++) drive(8'h01 << i, 8'h05);
    bus.out_ready = 1'b1;
    drive(8'h80, 8'h05);
    checks++;
    if (bus.frame_valid !== 1'b1 || bus.frame_sum !== 11'd40 || bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL load_on_transfer got v=%b s=%0d ov=%b required v=1 s=40 ov=0", bus.frame_valid, bus.frame_sum, bus.overrun);
    end
    drive(8'h00, 8'h00);
    checks++;
    if (bus.frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_drain got v=%b required 0", bus.frame_valid);
    end
  endtask

  task automatic test_mid_reset;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) drive(8'h01 << i, 8'(i + 1));
    drive(8'h01, 8'h09);
    drive(8'h02, 8'h09);
    drive(8'h04, 8'h09);
    drive(8'h08, 8'h09);
    clear = 1'b0;
    drive(8'h10, 8'h09);
    checks++;
    if (bus.frame_valid !== 1'b0 || bus.frame_sum !== 11'd0 || bus.frame_xor !== 8'h00 ||
        bus.phase_idx !== 3'd0 || bus.err_count !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset got v=%b s=%0d x=%h idx=%0d ec=%0d required all 0",
               bus.frame_valid, bus.frame_sum, bus.frame_xor, bus.phase_idx, bus.err_count);
    end
    clear = 1'b1;
    bus.out_ready = 1'b1;
    push_frame(11'd92, 8'h10);
    for (int i = 0; i < 8; i++) drive(8'h01 << i, 8'(i * 3 + 1));
    checks++;
    if (bus.frame_valid !== 1'b1 || bus.frame_sum !== 11'd92 || bus.frame_xor !== 8'h10) begin
      errors++;
      $display("FAIL post_reset_frame got v=%b s=%0d x=%h required v=1 s=92 x=10", bus.frame_valid, bus.frame_sum, bus.frame_xor);
    end
    drive(8'h00, 8'h00);
  endtask

  task automatic test_wait_sync_multihot;
    logic exp_pe;
`ifdef RING_ONEHOT_CHECK_EN
    exp_pe = 1'b1;
`else
    exp_pe = 1'b0;
`endif
    drive(8'h03, 8'h00);
    checks++;
    if (bus.phase_err !== exp_pe) begin
      errors++;
      $display("FAIL wait_sync_multihot got pe=%b required %b", bus.phase_err, exp_pe);
    end
    drive(8'h00, 8'h00);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear = 1'b0;
    bus.phase = 8'h00;
    bus.din = 8'h00;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic_ring();
    test_back_to_back();
    test_phase_error();
    test_overrun();
    test_load_on_transfer();
    test_mid_reset();
    test_wait_sync_multihot();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ring_phase_collector.md
Name: ring_phase_collector

Overview:
- Sits directly downstream of the 8-bit one-hot ring counter stage. It consumes the ring's phase word plus a data byte that is presented once per phase.
- Checks that the ring advances in the legal order 01→02→…→80 and accumulates one byte per phase.
- After a full revolution, presents the frame sum and frame XOR on a valid/ready output register.
- Flags phase-sequence errors and frame overruns.

Parameters:
- WIDTH, 8, data byte width; the sum is WIDTH+3 bits wide. Phase width is fixed at 8.
- ERR_MAX, 255, saturation value of err_count; must be ≤ 255.

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  one clock; reset is synchronous and active-low (clear==0 at posedge clk resets).
- phase  input  8  one-hot phase from the ring counter stage.
- din  input  WIDTH  data byte for the current phase.
- out_ready  input  1  consumer accepts the frame when high together with frame_valid.
- frame_valid  output  1  frame_sum/frame_xor hold an unconsumed frame.
- frame_sum  output  WIDTH+3  unsigned sum of the 8 bytes of the frame.
- frame_xor  output  WIDTH  bitwise XOR of the 8 bytes.
- phase_idx  output  3  binary index of phase, registered (01→0 … 80→7); 0 when phase is not one-hot.
- phase_err  output  1  one-cycle pulse on a sequence error.
- overrun  output  1  one-cycle pulse when a completed frame is dropped.
- err_count  output  8  saturating count of phase_err pulses.

Behaviour:
- Reset (clear==0): state=WAIT_SYNC. frame_valid=0, frame_sum=0, frame_xor=0, phase_idx=0, phase_err=0, overrun=0, err_count=0. Accumulators and expected phase are set to 0.
- All outputs are registered. phase_idx lags phase by 1 cycle.
- State WAIT_SYNC:
  - On phase==8'h01: acc_sum=din, acc_xor=din, exp=8'h02, go to COLLECT.
  - Any other phase value: stay in WAIT_SYNC; no error is raised.
- State COLLECT:
  - If phase==exp and exp≠8'h80: acc_sum+=din (zero-extended), acc_xor^=din, exp<<=1.
  - If phase==exp==8'h80: compute the final sum and XOR including din, "complete" the frame, and go to WAIT_SYNC.
  - If phase≠exp (including 0 or multi-hot): phase_err=1 for 1 cycle, err_count+1 (saturating at ERR_MAX), discard the accumulators, go to WAIT_SYNC.
  - An erroring cycle is never reused as a sync; a valid 01 resynchronises on the following cycle at the earliest.
- Frame completion:
  - If frame_valid==0, or frame_valid&&out_ready in the same cycle: load frame_sum/frame_xor and set frame_valid=1 on the next edge.
  - If frame_valid&&!out_ready: the new frame is dropped, overrun=1 for 1 cycle, and the held frame is unchanged.
- Handshake:
  - A transfer occurs on a cycle with frame_valid&&out_ready. frame_valid clears on the next edge unless a completion loads simultaneously, in which case it stays 1 with the new data.
  - frame_sum/frame_xor are stable while frame_valid&&!out_ready.
- Latency: the phase-80 cycle → frame_valid high on the following edge (1 cycle). A back-to-back ring (01 immediately after 80) is collected with no gap.
- Reset mid-frame: the partial frame is lost and the held output frame is cleared. The first post-reset 01 starts a clean frame.
- Arithmetic: maximum sum is 8×(2^WIDTH−1), which fits in WIDTH+3 bits; there is no wrap.

Optional Feature:
- Macro: RING_ONEHOT_CHECK_EN.
- Defined: in WAIT_SYNC, a non-one-hot phase (0 or more than one bit set) also pulses phase_err and increments err_count. In COLLECT, behaviour is unchanged.
- Undefined: WAIT_SYNC silently ignores every value except 8'h01.

Test Plan:
- Reset, then ring 01..80 with din=1..8 and out_ready=1 → 1 cycle after phase 80: frame_valid=1, frame_sum=36, frame_xor=8'h08; frame_valid=0 on the next cycle. phase_idx tracks 0..7.
- Two back-to-back rings, din=8'hFF every cycle, out_ready=1 → two frames, each frame_sum=2040, frame_xor=0, no overrun.
- Ring with phase 04 repeated in place of 08 → phase_err pulse, err_count=1, no frame. The next clean ring produces a correct frame.
- Complete frame A with out_ready=0, then complete frame B → overrun pulse; frame A's values are still held. Raise out_ready → frame A is consumed and frame_valid drops.
- out_ready asserted in the same cycle a new frame completes → frame_valid stays 1 and new values appear, no overrun.
- Assert clear=0 at phase 10 with frame_valid=1 → all outputs 0 next cycle; after clear=1, a full ring yields a correct frame. With RING_ONEHOT_CHECK_EN defined: phase=8'h03 in WAIT_SYNC → phase_err pulse.
